// File: rtl/pc_tx.sv
// pc_tx: FIFO-buffered 32-bit word transmitter, bytes [31:24]..[7:0] as 8N1 LSB first.
// Define PC_TX_CHECKSUM_EN to append an XOR checksum byte after each word.
module pc_tx #(
    parameter int CLKS_PER_BIT = 435,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_write_word_cmd,
    input  logic [31:0] i_tx_word,
    output logic        o_fifo_is_full_sig,
    output logic        o_fifo_is_empty_sig,
    output logic        o_word_dropped,
    output logic        o_tx_busy,
    output logic        o_word_sent,
    output logic        o_tx_serial
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [NW-1:0] DEPTH   = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
`ifdef PC_TX_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, drop_q, drop_d;
    logic          push, pop;
    logic [31:0]   head;

    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   word_q, word_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, busy_q, busy_d, sent_q, sent_d;
    logic          bit_end, start_bit;
`ifdef PC_TX_CHECKSUM_EN
    logic          chk_q, chk_d;
    logic [7:0]    sum_q, sum_d;
`endif

    // FIFO bookkeeping; a push is refused whenever the start-of-cycle count is full
    always_comb begin
        push     = i_write_word_cmd && !full_q;
        pop      = (state_q == S_LOAD);
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0);
        drop_d  = i_write_word_cmd && full_q;
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_tx_word;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bit_end = (cnt_q == CNT_MAX);
    assign cnt_nxt = bit_end ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!empty_q) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != 2'd3) begin
                        state_d = S_START;
`ifdef PC_TX_CHECKSUM_EN
                    end else if (!chk_q) begin
                        state_d = S_CHK;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef PC_TX_CHECKSUM_EN
            S_CHK:   if (bit_end) state_d = S_DATA;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = '0;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        shift_d    = shift_q;
`ifdef PC_TX_CHECKSUM_EN
        chk_d      = chk_q;
        sum_d      = sum_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                shift_d    = head[31:24];
                word_d     = head[23:0];
                byte_idx_d = '0;
                bit_d      = '0;
`ifdef PC_TX_CHECKSUM_EN
                chk_d      = 1'b0;
                sum_d      = head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
`endif
            end
            S_START: cnt_d = cnt_nxt;
            S_DATA: begin
                cnt_d = cnt_nxt;
                if (bit_end) begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_STOP: begin
                cnt_d = cnt_nxt;
                if (bit_end && byte_idx_q != 2'd3) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    shift_d    = word_q[23:16];
                    word_d     = {word_q[15:0], 8'h00};
`ifdef PC_TX_CHECKSUM_EN
                end else if (bit_end && !chk_q) begin
                    chk_d   = 1'b1;
                    shift_d = sum_q;
`endif
                end
            end
`ifdef PC_TX_CHECKSUM_EN
            S_CHK: cnt_d = cnt_nxt;
`endif
            default: ;
        endcase
        start_bit = (state_d == S_START);
`ifdef PC_TX_CHECKSUM_EN
        start_bit = start_bit || (state_d == S_CHK);
`endif
        // line is registered from the next state so it changes with the FSM
        tx_d = 1'b1;
        if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end else if (start_bit) begin
            tx_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        sent_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
`ifdef PC_TX_CHECKSUM_EN
            chk_q      <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
`ifdef PC_TX_CHECKSUM_EN
            chk_q      <= chk_d;
            sum_q      <= sum_d;
`endif
        end
    end

    assign o_fifo_is_full_sig  = full_q;
    assign o_fifo_is_empty_sig = empty_q;
    assign o_word_dropped      = drop_q;
    assign o_tx_busy           = busy_q;
    assign o_word_sent         = sent_q;
    assign o_tx_serial         = tx_q;
endmodule

// File: tb/tb_pc_tx.sv
// tb_pc_tx: directed bench for pc_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background UART decoder collects bytes; each task checks its own scenario.
module tb_pc_tx;
    localparam int CPB = 4;
`ifdef PC_TX_CHECKSUM_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif
    localparam int FR = BPW * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd;
    logic [31:0] word;
    logic        full, empty, dropped, busy, sent, line;

    int n_tests = 0;
    int n_fail  = 0;
    int sent_cnt = 0;
    int drop_cnt = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];

    int t3_rx, t3_sent, t3_drop;

    always #5 clk = ~clk;

    pc_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_write_word_cmd(cmd),
        .i_tx_word(word),
        .o_fifo_is_full_sig(full),
        .o_fifo_is_empty_sig(empty),
        .o_word_dropped(dropped),
        .o_tx_busy(busy),
        .o_word_sent(sent),
        .o_tx_serial(line)
    );

    always @(negedge clk) begin
        if (sent === 1'b1) sent_cnt <= sent_cnt + 1;
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    initial begin : uart_mon
        logic prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && line === 1'b0) begin
                repeat (2) @(negedge clk);
                if (line !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = line;
                end
                repeat (CPB) @(negedge clk);
                if (line !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
            prev = line;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int j);
        logic [7:0] r;
        if (j < 4) r = w[31-8*j -: 8];
        else r = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        return r;
    endfunction

    task automatic test_reset();
        int edges;
        logic prev;
        rst_n = 1'b0;
        cmd = 1'b0;
        word = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({line, empty, full, busy, sent, dropped} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_outputs got line/empty/full/busy/sent/drop=%b expected 110000",
                     {line, empty, full, busy, sent, dropped});
        end
        edges = 0;
        prev = line;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (line !== prev) edges++;
            prev = line;
        end
        n_tests++;
        if (edges !== 0 || line !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_line got edges=%0d line=%b expected edges=0 line=1", edges, line);
        end
    endtask

    task automatic test_single_word();
        int k, t, rb, sb;
        logic e1;
        logic [39:0] bytes;
        bytes = 40'hA5C30F81E8;
        rb = rx_q.size();
        sb = sent_cnt;
        e1 = 1'b1;
        cmd = 1'b1;
        word = 32'hA5C30F81;
        k = 0;
        do begin
            @(negedge clk);
            cmd = 1'b0;
            k++;
            if (k == 1) e1 = empty;
        end while (line !== 1'b0 && k < 20);
        n_tests++;
        if (e1 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_after_push got %b expected 0", e1);
        end
        n_tests++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL first_fall_latency got %0d edges expected 3", k);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sent !== 1'b1 && t < 400);
        n_tests++;
        if (t !== FR) begin
            n_fail++;
            $display("FAIL word_sent_time got %0d cycles expected %0d", t, FR);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (rx_q.size() - rb !== BPW) begin
            n_fail++;
            $display("FAIL single_byte_count got %0d expected %0d", rx_q.size() - rb, BPW);
        end
        for (int j = 0; j < BPW; j++) begin
            n_tests++;
            if (rx_q[rb+j] !== bytes[39-8*j -: 8]) begin
                n_fail++;
                $display("FAIL single_byte%0d got %h expected %h", j, rx_q[rb+j], bytes[39-8*j -: 8]);
            end
        end
        n_tests++;
        if (sent_cnt - sb !== 1 || busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end got sent=%0d busy=%b empty=%b expected 1 0 1",
                     sent_cnt - sb, busy, empty);
        end
    endtask

    task automatic test_overflow();
        logic [6:1] dseen;
        t3_rx = rx_q.size();
        t3_sent = sent_cnt;
        t3_drop = drop_cnt;
        for (int i = 1; i <= 6; i++) begin
            cmd = 1'b1;
            word = 32'(i);
            @(negedge clk);
            dseen[i] = dropped;
        end
        cmd = 1'b0;
        n_tests++;
        if (dseen !== 6'b100000) begin
            n_fail++;
            $display("FAIL drop_pattern got %b expected 100000", dseen);
        end
        n_tests++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_overflow got %b expected 1", full);
        end
        @(negedge clk);
        n_tests++;
        if (dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_single_pulse got %b expected 0", dropped);
        end
    endtask

    task automatic test_full_pop_at_load();
        int t;
        logic [31:0] expw [6];
        expw = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h11223344};
        t = 0;
        while (sent !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL load_state got busy=%b full=%b expected 1 1", busy, full);
        end
        cmd = 1'b1;
        word = 32'hDEADBEEF;
        @(negedge clk);
        cmd = 1'b0;
        n_tests++;
        if ({dropped, full, empty} !== 3'b100) begin
            n_fail++;
            $display("FAIL pop_push_full got drop/full/empty=%b expected 100", {dropped, full, empty});
        end
        cmd = 1'b1;
        word = 32'h11223344;
        @(negedge clk);
        cmd = 1'b0;
        n_tests++;
        if (full !== 1'b1 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL refill got full=%b drop=%b expected 1 0", full, dropped);
        end
        t = 0;
        while (sent_cnt - t3_sent < 6 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (sent_cnt - t3_sent !== 6 || drop_cnt - t3_drop !== 2) begin
            n_fail++;
            $display("FAIL drain_counts got sent=%0d drops=%0d expected 6 2",
                     sent_cnt - t3_sent, drop_cnt - t3_drop);
        end
        n_tests++;
        if (rx_q.size() - t3_rx !== 6 * BPW || frame_err !== 0) begin
            n_fail++;
            $display("FAIL drain_bytes got %0d bytes %0d framing errors expected %0d 0",
                     rx_q.size() - t3_rx, frame_err, 6 * BPW);
        end
        for (int w = 0; w < 6; w++) begin
            for (int j = 0; j < BPW; j++) begin
                n_tests++;
                if (rx_q[t3_rx + w*BPW + j] !== exp_byte(expw[w], j)) begin
                    n_fail++;
                    $display("FAIL order_w%0d_b%0d got %h expected %h", w, j,
                             rx_q[t3_rx + w*BPW + j], exp_byte(expw[w], j));
                end
            end
        end
        n_tests++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle got empty=%b busy=%b expected 1 0", empty, busy);
        end
    endtask

    task automatic test_back_to_back();
        int k, t, d, rb, sb;
        logic [31:0] wa, wb;
        wa = 32'h3C5A9601;
        wb = 32'h0F0F00FF;
        rb = rx_q.size();
        sb = sent_cnt;
        cmd = 1'b1;
        word = wa;
        k = 0;
        do begin
            @(negedge clk);
            cmd = 1'b0;
            k++;
        end while (line !== 1'b0 && k < 20);
        cmd = 1'b1;
        word = wb;
        t = 0;
        do begin
            @(negedge clk);
            cmd = 1'b0;
            t++;
        end while (sent !== 1'b1 && t < 400);
        n_tests++;
        if (t !== FR) begin
            n_fail++;
            $display("FAIL b2b_first_sent got %0d cycles expected %0d", t, FR);
        end
        d = 0;
        do begin
            @(negedge clk);
            d++;
        end while (busy !== 1'b1 && d < 10);
        n_tests++;
        if (d !== 2) begin
            n_fail++;
            $display("FAIL b2b_idle_gap got %0d cycles expected 2", d);
        end
        @(negedge clk);
        n_tests++;
        if (line !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_start got line=%b expected 0", line);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sent !== 1'b1 && t < 400);
        n_tests++;
        if (t !== FR) begin
            n_fail++;
            $display("FAIL b2b_second_sent got %0d cycles expected %0d", t, FR);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (sent_cnt - sb !== 2 || rx_q.size() - rb !== 2 * BPW || frame_err !== 0) begin
            n_fail++;
            $display("FAIL b2b_counts got sent=%0d bytes=%0d ferr=%0d expected 2 %0d 0",
                     sent_cnt - sb, rx_q.size() - rb, frame_err, 2 * BPW);
        end
        for (int j = 0; j < 2 * BPW; j++) begin
            n_tests++;
            if (rx_q[rb+j] !== exp_byte((j < BPW) ? wa : wb, j % BPW)) begin
                n_fail++;
                $display("FAIL b2b_byte%0d got %h expected %h", j, rx_q[rb+j],
                         exp_byte((j < BPW) ? wa : wb, j % BPW));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s, f;
        logic prev;
        cmd = 1'b1;
        word = 32'hFFFF0000;
        @(negedge clk);
        word = 32'h12345678;
        @(negedge clk);
        word = 32'h9ABCDEF0;
        @(negedge clk);
        cmd = 1'b0;
        n_tests++;
        if (line !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_setup got line=%b empty=%b expected 0 0", line, empty);
        end
        repeat (90) @(negedge clk);
        n_tests++;
        if (line !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_data got line=%b busy=%b expected 0 1", line, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if ({line, empty, full, busy, sent} !== 5'b11000) begin
            n_fail++;
            $display("FAIL abort_reset got line/empty/full/busy/sent=%b expected 11000",
                     {line, empty, full, busy, sent});
        end
        s = 0;
        f = 0;
        prev = line;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sent === 1'b1) s++;
            if (prev === 1'b1 && line === 1'b0) f++;
            prev = line;
        end
        n_tests++;
        if (s !== 0 || f !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet got sent=%0d starts=%0d expected 0 0", s, f);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_overflow();
        test_full_pop_at_load();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
